mem_access: RTL

- MEM stage of the RISC-V pipeline. Sits directly downstream of the EX/MEM register and consumes its outputs.
- Drives a data-memory bus using a req/ack handshake with variable latency. Raises mem_stall while a memory access is outstanding.
- Owns the MEM/WB pipeline register and the write-back data mux; wb_data is fed back to the EX-stage forwarding path.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_timeout_ctr.sv | 44 ++++
 rtl/mem_access.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM pipeline stage.
// The capture-register struct is sized by XLEN_DEF, so the mem_access XLEN
// parameter must stay at this default.
package mem_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int TIMEOUT_CYC_DEF = 16;

    // IDLE: new accesses are launched from EX/MEM.
    // WAIT: an access is outstanding and is replayed from the capture registers.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Snapshot of an access that did not complete in its first cycle.
    typedef struct packed {
        logic [XLEN_DEF-1:0] addr;
        logic                we;
        logic [XLEN_DEF-1:0] wdata;
        logic [4:0]          rd;
        logic                mem_to_reg;
        logic                reg_write;
    } mem_req_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts WAIT cycles that pass without dmem_ack. It raises timeout_o in the
// cycle where the count has reached TIMEOUT_CYC-1 and the access is still
// unacknowledged. This module is only built when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,   // held while no access is outstanding
    input  logic inc_i,     // WAIT cycle without acknowledge
    output logic timeout_o
);

    localparam int             CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear outside WAIT, saturate at the abort threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_access.sv
// MEM stage of the RISC-V pipeline: it drives the data-memory req/ack bus,
// stalls the upstream pipeline while an access is outstanding, and owns the
// MEM/WB register and the write-back mux.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an access
// left unacknowledged for TIMEOUT_CYC WAIT cycles is aborted and the
// sticky mem_err flag is set. When it is undefined, WAIT can last
// indefinitely and mem_err is tied to 0.
module mem_access
    import mem_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic [XLEN-1:0] EX_MEM_alu_out,
    input  logic [XLEN-1:0] EX_MEM_dataB,
    input  logic [4:0]      EX_MEM_rd,
    input  logic            EX_MEM_mem_to_reg,
    input  logic            EX_MEM_reg_write,
    input  logic            EX_MEM_mem_read,
    input  logic            EX_MEM_mem_write,

    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,

    output logic            mem_stall,
    output logic            mem_err,

    output logic [XLEN-1:0] MEM_WB_alu_out,
    output logic [XLEN-1:0] MEM_WB_rdata,
    output logic [4:0]      MEM_WB_rd,
    output logic            MEM_WB_mem_to_reg,
    output logic            MEM_WB_reg_write,
    output logic [XLEN-1:0] wb_data
);

    mem_state_t      state_q;
    mem_state_t      state_d;
    mem_req_t        cap_q;
    mem_req_t        cap_d;

    logic [XLEN-1:0] wb_alu_q;
    logic [XLEN-1:0] wb_alu_d;
    logic [XLEN-1:0] wb_rdata_q;
    logic [XLEN-1:0] wb_rdata_d;
    logic [4:0]      wb_rd_q;
    logic [4:0]      wb_rd_d;
    logic            wb_m2r_q;
    logic            wb_m2r_d;
    logic            wb_rw_q;
    logic            wb_rw_d;

    logic            access_s;
    logic            is_store_s;
    logic            timeout_s;

    // A store takes priority when both read and write are flagged.
    assign access_s   = EX_MEM_mem_read | EX_MEM_mem_write;
    assign is_store_s = EX_MEM_mem_write;

`ifdef MEM_TIMEOUT_EN
    logic err_q;
    logic err_d;

    mem_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (state_q == IDLE),
        .inc_i     ((state_q == WAIT) && !dmem_ack),
        .timeout_o (timeout_s)
    );

    assign err_d = err_q | timeout_s;

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    logic unused_timeout_cfg_s;

    assign unused_timeout_cfg_s = (TIMEOUT_CYC > 0);
    assign timeout_s            = 1'b0;
    assign mem_err              = 1'b0;
`endif

    // Bus request and stall. In IDLE, the request comes straight from EX/MEM.
    // In WAIT, it is replayed from the capture registers so that it stays
    // stable. Both are gated by reset_n so that an abandoned access drops at
    // once, even while the frozen EX/MEM still shows an access.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = is_store_s;
        dmem_addr  = EX_MEM_alu_out;
        dmem_wdata = EX_MEM_dataB;
        mem_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                dmem_req  = reset_n & access_s;
                mem_stall = reset_n & access_s & ~dmem_ack;
            end
            WAIT: begin
                dmem_req   = reset_n;
                dmem_we    = cap_q.we;
                dmem_addr  = cap_q.addr;
                dmem_wdata = cap_q.wdata;
                mem_stall  = reset_n & ~dmem_ack;
            end
            default: begin
                dmem_req  = 1'b0;
                mem_stall = 1'b0;
            end
        endcase
    end

    // Next state, capture registers and MEM/WB contents. A bubble clears
    // reg_write and mem_to_reg and leaves the data fields unchanged.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        wb_alu_d   = wb_alu_q;
        wb_rdata_d = wb_rdata_q;
        wb_rd_d    = wb_rd_q;
        wb_m2r_d   = wb_m2r_q;
        wb_rw_d    = wb_rw_q;
        case (state_q)
            IDLE: begin
                if (access_s) begin
                    if (dmem_ack) begin
                        wb_alu_d   = EX_MEM_alu_out;
                        wb_rdata_d = dmem_rdata;
                        wb_rd_d    = EX_MEM_rd;
                        wb_m2r_d   = EX_MEM_mem_to_reg;
                        wb_rw_d    = EX_MEM_reg_write;
                    end else begin
                        cap_d.addr       = EX_MEM_alu_out;
                        cap_d.we         = is_store_s;
                        cap_d.wdata      = EX_MEM_dataB;
                        cap_d.rd         = EX_MEM_rd;
                        cap_d.mem_to_reg = EX_MEM_mem_to_reg;
                        cap_d.reg_write  = EX_MEM_reg_write;
                        wb_m2r_d         = 1'b0;
                        wb_rw_d          = 1'b0;
                        state_d          = WAIT;
                    end
                end else begin
                    wb_alu_d = EX_MEM_alu_out;
                    wb_rd_d  = EX_MEM_rd;
                    wb_m2r_d = EX_MEM_mem_to_reg;
                    wb_rw_d  = EX_MEM_reg_write;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    wb_alu_d   = cap_q.addr;
                    wb_rdata_d = dmem_rdata;
                    wb_rd_d    = cap_q.rd;
                    wb_m2r_d   = cap_q.mem_to_reg;
                    wb_rw_d    = cap_q.reg_write;
                    state_d    = IDLE;
                end else if (timeout_s) begin
                    // Abort: the access is squashed and never reaches write-back.
                    wb_m2r_d = 1'b0;
                    wb_rw_d  = 1'b0;
                    state_d  = IDLE;
                end else begin
                    wb_m2r_d = 1'b0;
                    wb_rw_d  = 1'b0;
                end
            end
            default: begin
                wb_m2r_d = 1'b0;
                wb_rw_d  = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // FSM state, capture registers and the MEM/WB pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            wb_alu_q   <= '0;
            wb_rdata_q <= '0;
            wb_rd_q    <= 5'd0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            wb_rd_q    <= wb_rd_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
        end
    end

    assign MEM_WB_alu_out    = wb_alu_q;
    assign MEM_WB_rdata      = wb_rdata_q;
    assign MEM_WB_rd         = wb_rd_q;
    assign MEM_WB_mem_to_reg = wb_m2r_q;
    assign MEM_WB_reg_write  = wb_rw_q;

    // The write-back value also feeds the EX-stage forwarding path.
    assign wb_data = wb_m2r_q ? wb_rdata_q : wb_alu_q;

endmodule
